// File: rtl/slc3_io_pkg.sv
// slc3_io_pkg: shared key-channel states and defaults for the SLC-3 board input front-end
package slc3_io_pkg;
    typedef enum logic [1:0] {REL, PRESS_WAIT, PRESSED, REL_WAIT} btn_state_t;
    localparam logic KEY_RELEASED = 1'b1;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int CNT_W_DEFAULT = 20;
    function automatic logic is_held(btn_state_t s);
        return s == PRESSED || s == REL_WAIT;
    endfunction
endpackage

// File: rtl/slc3_debounce_channel.sv
// slc3_debounce_channel: synchronises one active-low key and debounces it into a held level and a press event
module slc3_debounce_channel
    import slc3_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_raw,
    output logic held,
    output logic held_nxt,
    output logic rel_nxt,
    output logic press_evt
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic key_s1, key_s2, pressed, evt_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    btn_state_t state, state_d;
    assign pressed = key_s2 != KEY_RELEASED;
    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1 <= KEY_RELEASED;
            key_s2 <= KEY_RELEASED;
            state <= REL;
            cnt <= '0;
            press_evt <= 1'b0;
        end else begin
            key_s1 <= key_n_raw;
            key_s2 <= key_s1;
            state <= state_d;
            cnt <= cnt_d;
            press_evt <= evt_d;
        end
    end
    // any sample disagreeing with the pending level restarts the stability count
    always_comb begin
        state_d = state;
        cnt_d = cnt;
        unique case (state)
            REL: begin
                state_d = pressed ? PRESS_WAIT : REL;
                cnt_d = pressed ? CNT_W'(1) : '0;
            end
            PRESS_WAIT: begin
                state_d = !pressed ? REL : cnt >= LAST ? PRESSED : PRESS_WAIT;
                cnt_d = (!pressed || cnt >= LAST) ? '0 : cnt + CNT_W'(1);
            end
            PRESSED: begin
                state_d = pressed ? PRESSED : REL_WAIT;
                cnt_d = pressed ? '0 : CNT_W'(1);
            end
            REL_WAIT: begin
                state_d = pressed ? PRESSED : cnt >= LAST ? REL : REL_WAIT;
                cnt_d = (pressed || cnt >= LAST) ? '0 : cnt + CNT_W'(1);
            end
        endcase
    end
    always_comb begin
        held = is_held(state);
        held_nxt = is_held(state_d);
        rel_nxt = state_d == REL;
        evt_d = state == PRESS_WAIT && state_d == PRESSED;
    end
endmodule

// File: rtl/slc3_button_conditioner.sv
// slc3_button_conditioner: synchronised switches, debounced Run/Continue pulses and a both-keys combo reset
module slc3_button_conditioner
    import slc3_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int SW_W = 10
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Run_n_raw,
    input  logic            Continue_n_raw,
    input  logic [SW_W-1:0] SW_raw,
    output logic [SW_W-1:0] SW_sync,
    output logic            Run_pulse,
    output logic            Continue_pulse,
    output logic            Run_held,
    output logic            Continue_held,
    output logic            Combo_reset
);
    logic [SW_W-1:0] sw_s1;
    logic run_held_nxt, run_rel_nxt, run_evt;
    logic cont_held_nxt, cont_rel_nxt, cont_evt;
    slc3_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_run (
        .clk(Clk),
        .rst(Reset),
        .key_n_raw(Run_n_raw),
        .held(Run_held),
        .held_nxt(run_held_nxt),
        .rel_nxt(run_rel_nxt),
        .press_evt(run_evt)
    );
    slc3_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_cont (
        .clk(Clk),
        .rst(Reset),
        .key_n_raw(Continue_n_raw),
        .held(Continue_held),
        .held_nxt(cont_held_nxt),
        .rel_nxt(cont_rel_nxt),
        .press_evt(cont_evt)
    );
    // the combo latch sets with the second acceptance and gates any press event still in flight
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sw_s1 <= '0;
            SW_sync <= '0;
            Combo_reset <= 1'b0;
            Run_pulse <= 1'b0;
            Continue_pulse <= 1'b0;
        end else begin
            sw_s1 <= SW_raw;
            SW_sync <= sw_s1;
            Combo_reset <= (run_held_nxt && cont_held_nxt) || (Combo_reset && !(run_rel_nxt && cont_rel_nxt));
            Run_pulse <= run_evt && !Combo_reset;
            Continue_pulse <= cont_evt && !Combo_reset;
        end
    end
endmodule

// File: tb/tb_slc3_button_conditioner.sv
// tb_slc3_button_conditioner: scoreboard bench with a sample-window reference model of the key conditioner
module tb_slc3_button_conditioner;
    localparam int D = 4;
    localparam int SW_W = 10;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic Run_n_raw = 1'b1;
    logic Continue_n_raw = 1'b1;
    logic [SW_W-1:0] SW_raw = '0;
    logic [SW_W-1:0] SW_sync;
    logic Run_pulse, Continue_pulse, Run_held, Continue_held, Combo_reset;
    typedef struct packed {
        logic [SW_W-1:0] sw;
        logic [4:0] ctrl;
    } exp_t;
    exp_t expq[$];
    exp_t mon_e;
    int checks = 0;
    int failures = 0;
    int run_pulses = 0;
    int cont_pulses = 0;
    logic [1:0] pipe [2];
    logic [D-1:0] seen [2];
    logic lvl [2];
    logic acc [2];
    logic rel [2];
    logic latch_m;
    logic [SW_W-1:0] sw_prev;

    slc3_button_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(20), .SW_W(SW_W)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Run_n_raw(Run_n_raw),
        .Continue_n_raw(Continue_n_raw),
        .SW_raw(SW_raw),
        .SW_sync(SW_sync),
        .Run_pulse(Run_pulse),
        .Continue_pulse(Continue_pulse),
        .Run_held(Run_held),
        .Continue_held(Continue_held),
        .Combo_reset(Combo_reset)
    );

    always #5 Clk = ~Clk;

    // a key's level flips once its last D synchronised samples all disagree with it
    function automatic void model_edge(input logic rst, input logic [1:0] raw, input logic [SW_W-1:0] sw);
        exp_t e;
        logic p_r, p_c, s;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                pipe[k] = 2'b11;
                seen[k] = '1;
                lvl[k] = 1'b0;
                acc[k] = 1'b0;
                rel[k] = 1'b1;
            end
            latch_m = 1'b0;
            sw_prev = '0;
            e = '0;
        end else begin
            p_r = acc[0] && !latch_m;
            p_c = acc[1] && !latch_m;
            for (int k = 0; k < 2; k++) begin
                s = pipe[k][1];
                pipe[k] = {pipe[k][0], raw[k]};
                seen[k] = {seen[k][D-2:0], s};
                acc[k] = !lvl[k] && seen[k] == '0;
                if (lvl[k] ? &seen[k] : seen[k] == '0) lvl[k] = !lvl[k];
                rel[k] = !lvl[k] && seen[k][0];
            end
            latch_m = (lvl[0] && lvl[1]) || (latch_m && !(rel[0] && rel[1]));
            e.sw = sw_prev;
            sw_prev = sw;
            e.ctrl = {p_r, p_c, lvl[0], lvl[1], latch_m};
        end
        expq.push_back(e);
    endfunction

    task automatic step(input logic rst, input logic r, input logic c, input logic [SW_W-1:0] sw);
        @(negedge Clk);
        Reset = rst;
        Run_n_raw = r;
        Continue_n_raw = c;
        SW_raw = sw;
        model_edge(rst, {c, r}, sw);
    endtask

    task automatic hold(input int n, input logic rst, input logic r, input logic c, input logic [SW_W-1:0] sw);
        repeat (n) step(rst, r, c, sw);
    endtask

    task automatic check_count(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    initial forever begin
        @(posedge Clk);
        #1;
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            checks++;
            if (SW_sync !== mon_e.sw) begin
                failures++;
                $display("FAIL sw_sync t=%0t got=%h expected=%h", $time, SW_sync, mon_e.sw);
            end
            checks++;
            if ({Run_pulse, Continue_pulse, Run_held, Continue_held, Combo_reset} !== mon_e.ctrl) begin
                failures++;
                $display("FAIL ctrl{rp,cp,rh,ch,combo} t=%0t got=%b expected=%b", $time,
                         {Run_pulse, Continue_pulse, Run_held, Continue_held, Combo_reset}, mon_e.ctrl);
            end
            run_pulses += int'(Run_pulse);
            cont_pulses += int'(Continue_pulse);
        end
    end

    initial begin
        int r0, c0, left_r, left_c;
        logic tr, tc;
        logic [SW_W-1:0] swr;
        hold(2, 1'b1, 1'b0, 1'b1, '0);
        r0 = run_pulses;
        hold(12, 1'b0, 1'b0, 1'b1, '0);
        hold(10, 1'b0, 1'b1, 1'b1, '0);
        check_count("reset_run_pulse", run_pulses - r0, 1);
        c0 = cont_pulses;
        hold(3, 1'b0, 1'b1, 1'b0, '0);
        hold(10, 1'b0, 1'b1, 1'b1, '0);
        check_count("glitch_cont_pulse", cont_pulses - c0, 0);
        c0 = cont_pulses;
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, '0);
        hold(10, 1'b0, 1'b1, 1'b0, '0);
        hold(10, 1'b0, 1'b1, 1'b1, '0);
        check_count("bounce_cont_pulse", cont_pulses - c0, 1);
        c0 = cont_pulses;
        hold(50, 1'b0, 1'b1, 1'b0, '0);
        hold(12, 1'b0, 1'b1, 1'b1, '0);
        check_count("held_cont_pulse", cont_pulses - c0, 1);
        r0 = run_pulses;
        c0 = cont_pulses;
        hold(20, 1'b0, 1'b0, 1'b0, '0);
        hold(20, 1'b0, 1'b1, 1'b0, '0);
        hold(20, 1'b0, 1'b1, 1'b1, '0);
        check_count("simul_pulses", (run_pulses - r0) + (cont_pulses - c0), 0);
        r0 = run_pulses;
        c0 = cont_pulses;
        hold(10, 1'b0, 1'b0, 1'b1, '0);
        hold(20, 1'b0, 1'b0, 1'b0, '0);
        hold(20, 1'b0, 1'b1, 1'b1, '0);
        check_count("stagger_run_pulse", run_pulses - r0, 1);
        check_count("stagger_cont_pulse", cont_pulses - c0, 0);
        r0 = run_pulses;
        c0 = cont_pulses;
        hold(15, 1'b0, 1'b0, 1'b0, '0);
        hold(10, 1'b0, 1'b1, 1'b0, '0);
        hold(10, 1'b0, 1'b0, 1'b0, '0);
        hold(15, 1'b0, 1'b1, 1'b1, '0);
        check_count("repress_pulses", (run_pulses - r0) + (cont_pulses - c0), 0);
        hold(3, 1'b0, 1'b1, 1'b1, 10'h031);
        hold(3, 1'b0, 1'b1, 1'b1, 10'h002);
        step(1'b0, 1'b1, 1'b1, 10'h003);
        step(1'b1, 1'b1, 1'b1, 10'h003);
        hold(4, 1'b0, 1'b1, 1'b1, 10'h003);
        tr = 1'b1;
        tc = 1'b1;
        left_r = 0;
        left_c = 0;
        swr = '0;
        for (int i = 0; i < 3000; i++) begin
            if (left_r == 0) begin
                tr = !tr;
                left_r = $urandom_range(3, 40);
            end
            if (left_c == 0) begin
                tc = !tc;
                left_c = $urandom_range(3, 40);
            end
            left_r--;
            left_c--;
            if ($urandom_range(0, 7) == 0) swr = SW_W'($urandom);
            step($urandom_range(0, 299) == 0, tr ^ ($urandom_range(0, 7) == 0),
                 tc ^ ($urandom_range(0, 7) == 0), swr);
        end
        hold(5, 1'b0, 1'b1, 1'b1, swr);
        @(posedge Clk);
        #2;
        check_count("scoreboard_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
